ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_pkg.sv | 79 +++++++
 rtl/mdu_div_iter.sv | 96 +++++++++
 rtl/ex_mdu.sv | 199 +++++++++++++++++++
 tb/tb_ex_mdu.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - mdu_op_e      : op_i encoding driven by EX
//   - mdu_state_e   : ex_mdu control state
//   - Funct*        : MIPS funct codes EX decodes into mdu_op_e
//   - helpers       : op classification used by ex_mdu
package ex_mdu_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMadd  = 3'd4,
    OpMaddu = 3'd5,
    OpMsub  = 3'd6,
    OpMsubu = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StFin  = 2'd3
  } mdu_state_e;

  // SPECIAL funct codes
  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;
  localparam logic [5:0] FunctDiv   = 6'h1a;
  localparam logic [5:0] FunctDivu  = 6'h1b;
  // SPECIAL2 funct codes
  localparam logic [5:0] FunctMadd  = 6'h00;
  localparam logic [5:0] FunctMaddu = 6'h01;
  localparam logic [5:0] FunctMsub  = 6'h04;
  localparam logic [5:0] FunctMsubu = 6'h05;

  // Maps an instruction funct field to an MDU op; valid_o low if not an MDU op.
  function automatic mdu_op_e decode_mdu_op(input logic special2, input logic [5:0] funct,
                                            output logic valid_o);
    mdu_op_e op;
    op      = OpMult;
    valid_o = 1'b1;
    if (!special2) begin
      case (funct)
        FunctMult:  op = OpMult;
        FunctMultu: op = OpMultu;
        FunctDiv:   op = OpDiv;
        FunctDivu:  op = OpDivu;
        default:    valid_o = 1'b0;
      endcase
    end else begin
      case (funct)
        FunctMadd:  op = OpMadd;
        FunctMaddu: op = OpMaddu;
        FunctMsub:  op = OpMsub;
        FunctMsubu: op = OpMsubu;
        default:    valid_o = 1'b0;
      endcase
    end
    return op;
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OpMult) || (op == OpDiv) || (op == OpMadd) || (op == OpMsub);
  endfunction

  function automatic logic op_is_accum(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input mdu_op_e op);
    return (op == OpMsub) || (op == OpMsubu);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider on unsigned W-bit magnitudes.
// One quotient bit per cycle; done_o pulses in the cycle after the last iteration,
// with quot_o/rem_o valid while done_o is high (and held until the next start).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   abort_i              drop the division in flight (no done_o)
//   start_i              load dividend_i/divisor_i and begin (divisor must be nonzero)
//   busy_o               iterations in progress
//   done_o               single-cycle completion pulse
//   quot_o, rem_o        magnitude quotient and remainder
module mdu_div_iter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort_i,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dvs_q, dvs_d;

  // Partial remainder shifted left with the next dividend bit; since rem_q < dvs_q
  // the trial difference fits in W+1 bits and its MSB is the borrow.
  logic [W:0] rem_sh;
  logic [W:0] diff;
  assign rem_sh = {rem_q, quo_q[W-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(W);
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit writing HI/LO.
// Multiplies go through a MUL_LAT-deep register pipeline (the final stage is the
// HI/LO output register); divides use mdu_div_iter on magnitudes plus a sign-fix cycle.
// Build option: define EX_MDU_ACCUM_EN to implement MADD(U)/MSUB(U); otherwise those
// op codes complete after MUL_LAT cycles without a HI/LO write.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i, op_i            launch op_i (accepted only when idle)
//   opa_i, opb_i             rs/rt operands (dividend/divisor)
//   hi_i, lo_i               forwarded HI/LO for accumulate ops
//   flush_i                  abort the op in flight; suppresses the write in FIN
//   stall_o                  hold EX while the op runs
//   done_o                   single-cycle completion pulse
//   whilo_o, hi_o, lo_o      HI/LO write request and data (data held between results)
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] opa_i,
  input  logic [W-1:0] opb_i,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic         flush_i,
  output logic         stall_o,
  output logic         done_o,
  output logic         whilo_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  mdu_state_e   state_q, state_d;
  logic [1:0]   mul_cnt_q, mul_cnt_d;
  logic         wr_q, wr_d;
  logic         neg_quo_q, neg_quo_d;
  logic         neg_rem_q, neg_rem_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;

  mdu_op_e op;
  logic    sgn;
  logic    accept;
  logic    acc_en;
  assign op     = mdu_op_e'(op_i);
  assign sgn    = op_is_signed(op);
  assign accept = (state_q == StIdle) && start_i && !flush_i;

  // Product (and accumulate) is formed from the live inputs; it is captured
  // into the pipeline only on the accept edge.
  logic [2*W-1:0] a_ext, b_ext, product, prod_in, mul_res;
  assign a_ext   = sgn ? {{W{opa_i[W-1]}}, opa_i} : {{W{1'b0}}, opa_i};
  assign b_ext   = sgn ? {{W{opb_i[W-1]}}, opb_i} : {{W{1'b0}}, opb_i};
  assign product = a_ext * b_ext;

`ifdef EX_MDU_ACCUM_EN
  assign acc_en = 1'b1;
  always_comb begin
    prod_in = product;
    if (op_is_accum(op)) begin
      prod_in = op_is_sub(op) ? ({hi_i, lo_i} - product) : ({hi_i, lo_i} + product);
    end
  end
`else
  assign acc_en  = 1'b0;
  assign prod_in = product;
  logic unused_acc;
  assign unused_acc = ^{hi_i, lo_i};
`endif

  if (MUL_LAT == 1) begin : g_lat1
    assign mul_res = prod_in;
  end else begin : g_pipe
    logic [2*W-1:0] pipe_q [MUL_LAT-1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k < MUL_LAT - 1; k++) pipe_q[k] <= '0;
      end else begin
        if (accept) pipe_q[0] <= prod_in;
        for (int unsigned k = 1; k < MUL_LAT - 1; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end
    assign mul_res = pipe_q[MUL_LAT-2];
  end

  // Divider works on magnitudes; -2^(W-1) maps to 2^(W-1) as an unsigned value.
  logic [W-1:0] mag_a, mag_b, div_quo, div_rem;
  logic         div_start, div_done, unused_div_busy;
  assign mag_a = (sgn && opa_i[W-1]) ? (~opa_i + 1'b1) : opa_i;
  assign mag_b = (sgn && opb_i[W-1]) ? (~opb_i + 1'b1) : opb_i;

  mdu_div_iter #(
    .W(W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .abort_i    (flush_i),
    .start_i    (div_start),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .busy_o     (unused_div_busy),
    .done_o     (div_done),
    .quot_o     (div_quo),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    wr_d      = wr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          wr_d      = op_is_accum(op) ? acc_en : 1'b1;
          neg_quo_d = sgn && (opa_i[W-1] ^ opb_i[W-1]);
          neg_rem_d = sgn && opa_i[W-1];
          if (op_is_div(op)) begin
            if (opb_i == '0) begin
              state_d = StFin;
              wr_d    = 1'b0;
            end else begin
              div_start = 1'b1;
              state_d   = StDiv;
            end
          end else if (MUL_LAT == 1) begin
            state_d = StFin;
            if (wr_d) {hi_d, lo_d} = mul_res;
          end else begin
            state_d   = StMul;
            mul_cnt_d = 2'(MUL_LAT - 2);
          end
        end
      end
      StMul: begin
        if (mul_cnt_q == 2'd0) begin
          state_d = StFin;
          if (wr_q) {hi_d, lo_d} = mul_res;
        end else begin
          mul_cnt_d = mul_cnt_q - 2'd1;
        end
      end
      StDiv: begin
        // Sign-fix cycle: remainder follows the dividend, quotient the sign product.
        if (div_done) begin
          state_d = StFin;
          hi_d    = neg_rem_q ? (~div_rem + 1'b1) : div_rem;
          lo_d    = neg_quo_q ? (~div_quo + 1'b1) : div_quo;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d   = StIdle;
      hi_d      = hi_q;
      lo_d      = lo_q;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mul_cnt_q <= 2'd0;
      wr_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      wr_q      <= wr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign stall_o = ((state_q == StIdle) && start_i) || (state_q == StMul) ||
                   (state_q == StDiv);
  assign done_o  = (state_q == StFin);
  assign whilo_o = (state_q == StFin) && wr_q && !flush_i;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
module tb_ex_mdu;

  localparam int unsigned W       = 32;
  localparam int unsigned MUL_LAT = 2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

`ifdef EX_MDU_ACCUM_EN
  localparam bit AccEn = 1'b1;
`else
  localparam bit AccEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [2:0]   op_i;
  logic [W-1:0] opa_i, opb_i, hi_i, lo_i;
  logic         flush_i;
  logic         stall_o, done_o, whilo_o;
  logic [W-1:0] hi_o, lo_o;

  always #5 clk = ~clk;

  ex_mdu #(
    .W       (W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .opa_i   (opa_i),
    .opb_i   (opb_i),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .done_o  (done_o),
    .whilo_o (whilo_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic (C-style truncating division).
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, b, h, l,
                                 output logic wr, output logic [31:0] eh, el,
                                 output int lat);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, p, acc, prod;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    acc = {h, l};
    wr  = 1'b1;
    lat = MUL_LAT;
    p   = '0;
    case (op)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = ua * ub;
      OP_DIV, OP_DIVU: begin
        lat = (b == 0) ? 1 : W + 2;
        if (b == 0) wr = 1'b0;
        else if (op == OP_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end else begin
          p = {32'(ua % ub), 32'(ua / ub)};
        end
      end
      default: begin
        if (op == OP_MADD || op == OP_MSUB) prod = sa * sb;
        else prod = ua * ub;
        p  = (op == OP_MADD || op == OP_MADDU) ? acc + prod : acc - prod;
        wr = AccEn;
      end
    endcase
    if (wr) {eh, el} = p;
    else begin
      eh = last_hi;
      el = last_lo;
    end
  endfunction

  // Launch one op at cycle 0 and observe until done_o (bounded).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, b, h, l,
                       output int lat, output logic wr, output logic [31:0] ho, lov,
                       output logic stall_ok);
    @(negedge clk);
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; hi_i = h; lo_i = l;
    #1 stall_ok = (stall_o === 1'b1);
    lat = -1; wr = 1'b0; ho = '0; lov = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        lat = c; wr = whilo_o; ho = hi_o; lov = lo_o;
        if (stall_o !== 1'b0) stall_ok = 1'b0;
        break;
      end else if (stall_o !== 1'b1) stall_ok = 1'b0;
      // Scramble inputs: results must depend only on the accepted values.
      start_i = 1'b0;
      opa_i = $urandom; opb_i = $urandom; hi_i = $urandom; lo_i = $urandom;
      op_i  = 3'($urandom);
    end
    start_i = 1'b0;
    @(negedge clk);
    check("done_single_pulse", done_o, 0);
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a, b,
                           h, l, input logic ewr, input logic [31:0] eh, el, input int elat);
    int          lat;
    logic        wr, sok;
    logic [31:0] ho, lov;
    do_op(op, a, b, h, l, lat, wr, ho, lov, sok);
    check({name, "_lat"}, lat, elat);
    check({name, "_whilo"}, wr, ewr);
    check({name, "_hi"}, ho, eh);
    check({name, "_lo"}, lov, el);
    check({name, "_stall"}, sok, 1);
    if (ewr) begin
      last_hi = eh;
      last_lo = el;
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, h, l;
    logic        wr;
    logic        keep;   // expect HI/LO unchanged
    logic [31:0] eh, el;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          nd, lat;
    logic        ewr;
    logic [31:0] eh, el, a, b, h, l, dh, dl;
    logic [2:0]  op;

    vecs[0]  = '{"mult_neg",   OP_MULT,  32'hFFFFFFFE, 32'h3, 0, 0, 1, 0, 32'hFFFFFFFF,
                 32'hFFFFFFFA, 2};
    vecs[1]  = '{"div_m7_2",   OP_DIV,   32'hFFFFFFF9, 32'h2, 0, 0, 1, 0, 32'hFFFFFFFF,
                 32'hFFFFFFFD, 34};
    vecs[2]  = '{"divu_big",   OP_DIVU,  32'hFFFFFFFF, 32'h10, 0, 0, 1, 0, 32'hF,
                 32'h0FFFFFFF, 34};
    vecs[3]  = '{"div_zero",   OP_DIV,   32'h1234, 32'h0, 0, 0, 0, 1, 0, 0, 1};
    vecs[4]  = '{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h0,
                 32'h80000000, 34};
    vecs[5]  = '{"multu_5x7",  OP_MULTU, 32'd5, 32'd7, 0, 0, 1, 0, 32'h0, 32'd35, 2};
    vecs[6]  = '{"maddu_wrap", OP_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, AccEn, !AccEn,
                 32'h1, 32'h0, 2};
    vecs[7]  = '{"msub_neg",   OP_MSUB,  32'd1, 32'd1, 32'h0, 32'h0, AccEn, !AccEn,
                 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
    vecs[8]  = '{"divu_1000",  OP_DIVU,  32'd1000, 32'd7, 0, 0, 1, 0, 32'd6, 32'd142, 34};
    vecs[9]  = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 0,
                 32'hFFFFFFFE, 32'h00000001, 2};
    vecs[10] = '{"div_7_m2",   OP_DIV,   32'd7, 32'hFFFFFFFE, 0, 0, 1, 0, 32'h1,
                 32'hFFFFFFFD, 34};
    vecs[11] = '{"mult_min",   OP_MULT,  32'h80000000, 32'h80000000, 0, 0, 1, 0,
                 32'h40000000, 32'h0, 2};

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
    opa_i = '0; opb_i = '0; hi_i = '0; lo_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", stall_o, 0);
    check("rst_done", done_o, 0);
    check("rst_whilo", whilo_o, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);

    foreach (vecs[i]) begin
      eh = vecs[i].keep ? last_hi : vecs[i].eh;
      el = vecs[i].keep ? last_lo : vecs[i].el;
      run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].l,
                vecs[i].wr, eh, el, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      h = $urandom;
      l = $urandom;
      ref_op(op, a, b, h, l, ewr, eh, el, lat);
      run_check("rand", op, a, b, h, l, ewr, eh, el, lat);
    end

    // Flush a divide at cycle 10: no completion, back to idle.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIV; opa_i = 32'd100; opb_i = 32'd3;
    nd = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o === 1'b1) nd++;
      flush_i = (c == 10);
    end
    flush_i = 1'b0;
    check("flush_no_done", nd, 0);
    check("flush_idle_stall", stall_o, 0);
    run_check("after_flush", OP_MULTU, 32'd5, 32'd7, 0, 0, 1, 32'd0, 32'd35, 2);

    // Start together with flush is discarded.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_MULT; opa_i = 32'd9; opb_i = 32'd9;
    nd = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      if (done_o === 1'b1) nd++;
    end
    check("flush_start_discard", nd, 0);

    // start_i while busy is ignored: one done, divide result.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; opa_i = 32'd1000; opb_i = 32'd7;
    nd = 0; lat = -1; dh = '0; dl = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        nd++;
        if (lat < 0) begin lat = c; dh = hi_o; dl = lo_o; end
      end
      start_i = (c == 3);
      op_i = OP_MULTU; opa_i = 32'd2; opb_i = 32'd2;
    end
    start_i = 1'b0;
    check("busy_start_ndone", nd, 1);
    check("busy_start_lat", lat, 34);
    check("busy_start_lo", dl, 32'd142);
    check("busy_start_hi", dh, 32'd6);

    // Flush in FIN suppresses the write request.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MULTU; opa_i = 32'd2; opb_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("fin_flush_done", done_o, 1);
    check("fin_flush_whilo", whilo_o, 0);
    @(negedge clk);
    flush_i = 1'b0;

    // Reset mid-divide with a stray start: no done, everything cleared.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIV; opa_i = 32'hFFFFFFF9; opb_i = 32'd2;
    nd = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start_i = (c == 3);
      op_i = OP_MULT;
      rst = (c == 5);
      if (done_o === 1'b1) nd++;
    end
    start_i = 1'b0; rst = 1'b0;
    check("rst_mid_no_done", nd, 0);
    check("rst_mid_stall", stall_o, 0);
    check("rst_mid_hi", hi_o, 0);
    check("rst_mid_lo", lo_o, 0);
    last_hi = '0;
    last_lo = '0;
    run_check("div0_after_rst", OP_DIVU, 32'd55, 32'd0, 0, 0, 0, 32'd0, 32'd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
